spi_sequencer: RTL

Command-driven sequencer for the SPI byte engine. Accepts a stream of 16-bit commands (high byte opcode, low byte argument) from the host-side bus, and runs byte transfers, manual chip-select framing and cycle delays in order. Captured MISO bytes go into a result FIFO. It sits between the host command path and the SPI byte engine, and owns that engine's `go` strobe exclusively.

---
 rtl/spi_seq_pkg.sv | 16 +
 rtl/sync_fifo.sv | 62 ++++++
 rtl/spi_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/spi_seq_pkg.sv
// Shared opcode values and FSM state encoding for the SPI command sequencer.
package spi_seq_pkg;

    localparam logic [7:0] OP_XFER    = 8'h00;
    localparam logic [7:0] OP_CS_ON   = 8'h01;
    localparam logic [7:0] OP_CS_OFF  = 8'h02;
    localparam logic [7:0] OP_XFER_NC = 8'h03;
    localparam logic [7:0] OP_DELAY   = 8'h04;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DELAY = 2'd2
    } seq_state_e;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; the head is visible whenever not empty
// and reads as zero while empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] pushData_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] popData_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] memQ [DEPTH];
    logic [AW-1:0]    wrPtrQ;
    logic [AW-1:0]    rdPtrQ;
    logic [CW-1:0]    countQ;
    logic             doPush;
    logic             doPop;

    assign empty_o = (countQ == '0);
    assign full_o  = (countQ == CW'(DEPTH));

    // A pop on an empty FIFO is ignored; a push while full is accepted only alongside a pop.
    assign doPop  = pop_i && !empty_o;
    assign doPush = push_i && (!full_o || doPop);

    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            countQ <= '0;
        end else begin
            if (doPush) begin
                wrPtrQ <= wrPtrQ + AW'(1);
            end
            if (doPop) begin
                rdPtrQ <= rdPtrQ + AW'(1);
            end
            if (doPush && !doPop) begin
                countQ <= countQ + CW'(1);
            end else if (doPop && !doPush) begin
                countQ <= countQ - CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (doPush) begin
            memQ[wrPtrQ] <= pushData_i;
        end
    end

    assign popData_o = empty_o ? '0 : memQ[rdPtrQ];

endmodule

// File: rtl/spi_sequencer.sv
// Command-driven sequencer: decodes 16-bit commands into SPI byte transfers,
// chip-select framing and cycle delays, capturing received bytes into a result FIFO.
module spi_sequencer
    import spi_seq_pkg::*;
#(
    parameter int CMD_DEPTH = 16,
    parameter int RES_DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cmd_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [7:0]  res_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  spi_in_data,
    output logic        spi_go,
    input  logic        spi_done,
    input  logic [7:0]  spi_out_data,
    output logic        cs_n,
    output logic        err,
    output logic        idle
);

    seq_state_e  stateQ, stateD;
    logic [7:0]  delayCntQ, delayCntD;
    logic        captureQ, captureD;
    logic        csNQ, csND;
    logic        errQ, errD;
    logic        spiGoQ, spiGoD;
    logic [7:0]  spiInDataQ, spiInDataD;

    logic [15:0] cmdHead;
    logic        cmdEmpty;
    logic        cmdFull;
    logic        cmdPop;
    logic        resFull;
    logic        resEmpty;
    logic        resPush;
    logic        dispatch;
    logic [7:0]  opcode;
    logic [7:0]  arg;

    sync_fifo #(.WIDTH(16), .DEPTH(CMD_DEPTH)) cmdFifo (
        .clock      (clock),
        .reset      (reset),
        .push_i     (cmd_valid),
        .pushData_i (cmd_data),
        .pop_i      (cmdPop),
        .popData_o  (cmdHead),
        .full_o     (cmdFull),
        .empty_o    (cmdEmpty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RES_DEPTH)) resFifo (
        .clock      (clock),
        .reset      (reset),
        .push_i     (resPush),
        .pushData_i (spi_out_data),
        .pop_i      (res_ready),
        .popData_o  (res_data),
        .full_o     (resFull),
        .empty_o    (resEmpty)
    );

    assign opcode = cmdHead[15:8];
    assign arg    = cmdHead[7:0];

    // The last delay cycle also decodes the head, so the next command pops n+1 edges after the delay pop.
    assign dispatch = (stateQ == ST_IDLE) || ((stateQ == ST_DELAY) && (delayCntQ == '0));

    always_ff @(posedge clock) begin
        if (reset) begin
            stateQ     <= ST_IDLE;
            delayCntQ  <= '0;
            captureQ   <= 1'b0;
            csNQ       <= 1'b1;
            errQ       <= 1'b0;
            spiGoQ     <= 1'b0;
            spiInDataQ <= '0;
        end else begin
            stateQ     <= stateD;
            delayCntQ  <= delayCntD;
            captureQ   <= captureD;
            csNQ       <= csND;
            errQ       <= errD;
            spiGoQ     <= spiGoD;
            spiInDataQ <= spiInDataD;
        end
    end

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            ST_WAIT:  if (spi_done) stateD = ST_IDLE;
            ST_DELAY: if (delayCntQ == '0) stateD = ST_IDLE;
            default:  stateD = ST_IDLE;
        endcase
        if (dispatch && !cmdEmpty) begin
            case (opcode)
                OP_XFER:    if (!resFull) stateD = ST_WAIT;
                OP_XFER_NC: stateD = ST_WAIT;
                OP_DELAY:   stateD = ST_DELAY;
                default:    ;
            endcase
        end
    end

    // A capturing transfer is only issued with a free result slot, so the push in WAIT never overflows.
    always_comb begin
        cmdPop     = 1'b0;
        spiGoD     = 1'b0;
        spiInDataD = spiInDataQ;
        csND       = csNQ;
        errD       = errQ;
        captureD   = captureQ;
        delayCntD  = ((stateQ == ST_DELAY) && (delayCntQ != '0)) ? delayCntQ - 8'd1 : delayCntQ;
        resPush    = (stateQ == ST_WAIT) && spi_done && captureQ;
        if (dispatch && !cmdEmpty) begin
            case (opcode)
                OP_XFER: begin
                    if (!resFull) begin
                        cmdPop     = 1'b1;
                        spiGoD     = 1'b1;
                        spiInDataD = arg;
                        captureD   = 1'b1;
                    end
                end
                OP_CS_ON: begin
                    cmdPop = 1'b1;
                    csND   = 1'b0;
                end
                OP_CS_OFF: begin
                    cmdPop = 1'b1;
                    csND   = 1'b1;
                end
                OP_XFER_NC: begin
                    cmdPop     = 1'b1;
                    spiGoD     = 1'b1;
                    spiInDataD = arg;
                    captureD   = 1'b0;
                end
                OP_DELAY: begin
                    cmdPop    = 1'b1;
                    delayCntD = arg;
                end
                default: begin
                    cmdPop = 1'b1;
                    errD   = 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready   = !cmdFull;
    assign res_valid   = !resEmpty;
    assign spi_go      = spiGoQ;
    assign spi_in_data = spiInDataQ;
    assign cs_n        = csNQ;
    assign err         = errQ;
    assign idle        = (stateQ == ST_IDLE) && cmdEmpty;

endmodule
